lsq_buffer: RTL and testbench
=============================

// Module: lsq_buffer
// PURPOSE
//  Circular load/store queue feeding the memory stage. Dispatch allocates entries in program order.
//  Each cycle the full entry array plus head/tail go to the memory stage, which returns a 1-indexed
//  update (pointer + entry). Commit retires entries at the head. Retiring a ready STORE drives a
//  one-outstanding write request to the data cache.
// PARAMETERS
//  LSQ_SIZE  8   number of entries; power of two, >= 2
//  PTR_W     $clog2(LSQ_SIZE)  width of head/tail indices
// PORTS
//  clk            in   1          rising-edge clock
//  reset          in   1          asynchronous, active-high
//  alloc_valid    in   1          dispatch requests an entry this cycle
//  alloc_category in   1          0=LOAD, 1=STORE
//  alloc_tag      in   32         ROB tag of the memory op
//  alloc_ready    out  1          entry available (count < LSQ_SIZE)
//  upd_pointer    in   PTR_W+1    memory-stage lsq_pointer; 0 = no update, k = entry k-1
//  upd_entry      in   lsq_entry  replacement address/value/ready for that entry
//  commit_valid   in   1          ROB commits the op whose tag is commit_tag
//  commit_tag     in   32         tag being committed
//  commit_ready   out  1          commit accepted this cycle
//  st_req_valid   out  1          store write request to D-cache
//  st_req_addr    out  32         store address
//  st_req_data    out  32         store data
//  st_req_ack     in   1          cache accepted the write
//  flush          in   1          squash every entry (mispredict)
//  lsq            out  lsq_entry[LSQ_SIZE]  registered entry array
//  lsq_head       out  PTR_W      oldest entry index
//  lsq_tail       out  PTR_W      next allocation index
//  lsq_empty      out  1          count == 0
// BEHAVIOUR
//  Entry fields: valid, category, tag, address, value, ready, color.
//  Empty entries hold valid=0, tag=32'hFFFF_FFFF, address=0, value=0, ready=0, color=0.
//  Reset (async):
//   - all entries empty; head=tail=count=0; color_ctr=0; FSM=IDLE.
//   - st_req_valid=0, st_req_addr=0, st_req_data=0; alloc_ready=1, commit_ready=0.
//  Alloc: alloc_valid & alloc_ready writes entry[tail] at the edge:
//   - valid=1, category/tag from inputs, ready=0, color=color_ctr.
//   - tail+1 mod LSQ_SIZE (wraps); color_ctr+1 (32-bit, wraps).
//   - alloc_ready uses current count only; a same-cycle retire does not free a slot for alloc.
//  Update: upd_pointer!=0 and entry[upd_pointer-1].valid:
//   - overwrite address, value, ready from upd_entry; tag/category/color unchanged.
//   - update to an invalid entry is dropped.
//  FSM IDLE:
//   - commit_ready = commit_valid & entry[head].valid & entry[head].tag==commit_tag
//     & (category==LOAD | ready).
//   - LOAD accepted: entry[head] emptied, head+1, same edge.
//   - STORE accepted: latch addr/data into st_req_*, st_req_valid=1 from next cycle, go STORE_WAIT.
//   - head store not ready: commit_ready=0; ROB holds commit_valid.
//  FSM STORE_WAIT:
//   - commit_ready=0; st_req_* held stable until st_req_ack.
//   - on ack: st_req_valid=0, entry[head] emptied, head+1, back to IDLE.
//   - store latency = 1 + cache ack cycles.
//  Same edge: alloc, update and retire together are legal; count += alloc - retire.
//   - update and retire on the same entry: retire wins.
//  Full (count==LSQ_SIZE): head==tail; alloc_ready=0. Empty: head==tail, count==0.
//  Flush (synchronous, highest priority):
//   - all entries empty; head=tail=count=0; FSM=IDLE; st_req_valid=0.
//   - color_ctr NOT reset.
//   - an in-flight store request is abandoned; the committed store is already architectural, so
//     flush in STORE_WAIT is illegal (assertion).
//  Reset mid-STORE_WAIT returns to reset state immediately; no ack expected afterwards.
// TESTING
//  1. alloc LOAD tag 5, STORE tag 6 -> entry0 {LOAD,5,color0}, entry1 {STORE,6,color1}; tail=2.
//  2. upd_pointer=2 {addr 0x100, val 0xAB, ready} -> entry1 updated; commit 5 then 6
//     -> st_req 0x100/0xAB; ack after 3 cycles -> lsq_empty=1.
//  3. 8 allocs -> alloc_ready=0, head==tail==0; 9th alloc ignored; retire one then alloc
//     -> tail wraps to 1.
//  4. commit STORE with ready=0 -> commit_ready=0, head unchanged until upd sets ready.
//  5. flush with 5 valid entries + alloc same cycle -> all empty, tail=0; next alloc color=prior+1.
//  6. reset asserted mid-cycle while st_req_valid=1 -> outputs return to reset values before next edge.

Source files
------------

// File: rtl/lsq_buffer.sv
// Circular load/store queue between dispatch and the memory stage.
// Ops retire in order at the head; a committed store drives one outstanding D-cache write.
package lsq_pkg;
  typedef struct packed {
    logic        valid;
    logic        category;
    logic [31:0] tag;
    logic [31:0] address;
    logic [31:0] value;
    logic        ready;
    logic [31:0] color;
  } lsq_entry;

  localparam logic CAT_LOAD  = 1'b0;
  localparam logic CAT_STORE = 1'b1;

  localparam lsq_entry LSQ_EMPTY_ENTRY = '{valid: 1'b0, category: 1'b0, tag: 32'hFFFF_FFFF,
                                           address: 32'h0, value: 32'h0, ready: 1'b0, color: 32'h0};
endpackage

module lsq_buffer import lsq_pkg::*; #(
  parameter int LSQ_SIZE = 8,
  parameter int PTR_W    = $clog2(LSQ_SIZE)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alloc_valid,
  input  logic                      alloc_category,
  input  logic [31:0]               alloc_tag,
  output logic                      alloc_ready,
  input  logic [PTR_W:0]            upd_pointer,
  input  lsq_entry                  upd_entry,
  input  logic                      commit_valid,
  input  logic [31:0]               commit_tag,
  output logic                      commit_ready,
  output logic                      st_req_valid,
  output logic [31:0]               st_req_addr,
  output logic [31:0]               st_req_data,
  input  logic                      st_req_ack,
  input  logic                      flush,
  output lsq_entry [LSQ_SIZE-1:0]   lsq,
  output logic [PTR_W-1:0]          lsq_head,
  output logic [PTR_W-1:0]          lsq_tail,
  output logic                      lsq_empty
);
  typedef enum logic {ST_IDLE, ST_STORE_WAIT} state_t;

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(LSQ_SIZE);

  state_t                  r_state, w_nextState;
  lsq_entry [LSQ_SIZE-1:0] r_lsq;
  logic [PTR_W-1:0]        r_head, r_tail;
  logic [PTR_W:0]          r_count;
  logic [31:0]             r_colorCtr;
  logic                    r_stValid;
  logic [31:0]             r_stAddr, r_stData;

  lsq_entry                w_headEntry;
  logic                    w_alloc, w_retire, w_commitStore, w_updHit;
  logic [PTR_W-1:0]        w_updIdx;
  logic                    w_unusedUpdFields;

  assign w_headEntry = r_lsq[r_head];
  // Retire in the same cycle does not free a slot: fullness looks at the registered count only.
  assign alloc_ready = (r_count < FULL_COUNT);
  assign w_alloc     = alloc_valid & alloc_ready;
  assign w_updHit    = (upd_pointer != '0) && (upd_pointer <= FULL_COUNT);
  assign w_updIdx    = PTR_W'(upd_pointer - (PTR_W+1)'(1));
  assign w_unusedUpdFields = ^{upd_entry.valid, upd_entry.category, upd_entry.tag, upd_entry.color};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (flush) begin
      w_nextState = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:       if (w_commitStore) w_nextState = ST_STORE_WAIT;
        ST_STORE_WAIT: if (st_req_ack)    w_nextState = ST_IDLE;
        default:       w_nextState = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    commit_ready  = 1'b0;
    w_commitStore = 1'b0;
    w_retire      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        commit_ready  = !flush && commit_valid && w_headEntry.valid &&
                        (w_headEntry.tag == commit_tag) &&
                        (w_headEntry.category == CAT_LOAD || w_headEntry.ready);
        w_commitStore = commit_ready && (w_headEntry.category == CAT_STORE);
        w_retire      = commit_ready && (w_headEntry.category == CAT_LOAD);
      end
      ST_STORE_WAIT: w_retire = st_req_ack;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LSQ_SIZE; i++) r_lsq[i] <= LSQ_EMPTY_ENTRY;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_colorCtr <= '0;
      r_stValid  <= 1'b0;
      r_stAddr   <= '0;
      r_stData   <= '0;
    end else if (flush) begin
      // The allocation colour keeps counting across a flush so younger ops stay distinguishable.
      for (int i = 0; i < LSQ_SIZE; i++) r_lsq[i] <= LSQ_EMPTY_ENTRY;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_stValid <= 1'b0;
    end else begin
      for (int i = 0; i < LSQ_SIZE; i++) begin
        if (w_retire && r_head == PTR_W'(i)) begin
          r_lsq[i] <= LSQ_EMPTY_ENTRY;
        end else if (w_alloc && r_tail == PTR_W'(i)) begin
          r_lsq[i] <= '{valid: 1'b1, category: alloc_category, tag: alloc_tag,
                        address: 32'h0, value: 32'h0, ready: 1'b0, color: r_colorCtr};
        end else if (w_updHit && w_updIdx == PTR_W'(i) && r_lsq[i].valid) begin
          r_lsq[i].address <= upd_entry.address;
          r_lsq[i].value   <= upd_entry.value;
          r_lsq[i].ready   <= upd_entry.ready;
        end
      end
      if (w_alloc) begin
        r_tail     <= r_tail + PTR_W'(1);
        r_colorCtr <= r_colorCtr + 32'd1;
      end
      if (w_retire) r_head <= r_head + PTR_W'(1);
      r_count <= r_count + (PTR_W+1)'(w_alloc) - (PTR_W+1)'(w_retire);
      if (w_commitStore) begin
        r_stValid <= 1'b1;
        r_stAddr  <= w_headEntry.address;
        r_stData  <= w_headEntry.value;
      end else if (r_state == ST_STORE_WAIT && st_req_ack) begin
        r_stValid <= 1'b0;
      end
    end
  end

  assign lsq          = r_lsq;
  assign lsq_head     = r_head;
  assign lsq_tail     = r_tail;
  assign lsq_empty    = (r_count == '0);
  assign st_req_valid = r_stValid;
  assign st_req_addr  = r_stAddr;
  assign st_req_data  = r_stData;

  // A committed store is architectural; squashing its write would lose it.
  assert property (@(posedge clk) disable iff (reset) !(flush && r_state == ST_STORE_WAIT));

endmodule

// File: tb/tb_lsq_buffer.sv
// Testbench for lsq_buffer: directed scenarios plus randomized traffic checked
// against a slot-level behavioural model of the queue.
module tb_lsq_buffer;
  import lsq_pkg::*;

  localparam int N = 8;
  localparam int PW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset;
  logic          alloc_valid, alloc_category, alloc_ready;
  logic [31:0]   alloc_tag;
  logic [PW:0]   upd_pointer;
  lsq_entry      upd_entry;
  logic          commit_valid, commit_ready;
  logic [31:0]   commit_tag;
  logic          st_req_valid, st_req_ack, flush;
  logic [31:0]   st_req_addr, st_req_data;
  lsq_entry [N-1:0] lsq;
  logic [PW-1:0] lsq_head, lsq_tail;
  logic          lsq_empty;

  int checks = 0;
  int errors = 0;

  // Reference model: physical slots plus head/count, advanced one clock edge at a time
  lsq_entry    mLsq [N];
  int          mHead, mCount;
  logic [31:0] mColor;
  bit          mWait;
  logic        mStValid;
  logic [31:0] mStAddr, mStData;

  always #5 clk = ~clk;

  lsq_buffer #(.LSQ_SIZE(N)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_category(alloc_category), .alloc_tag(alloc_tag),
    .alloc_ready(alloc_ready),
    .upd_pointer(upd_pointer), .upd_entry(upd_entry),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_ready(commit_ready),
    .st_req_valid(st_req_valid), .st_req_addr(st_req_addr), .st_req_data(st_req_data),
    .st_req_ack(st_req_ack), .flush(flush),
    .lsq(lsq), .lsq_head(lsq_head), .lsq_tail(lsq_tail), .lsq_empty(lsq_empty)
  );

  function automatic lsq_entry makeEmpty();
    lsq_entry e;
    e = '0;
    e.tag = 32'hFFFF_FFFF;
    return e;
  endfunction

  function automatic lsq_entry [N-1:0] emptyArray();
    lsq_entry [N-1:0] a;
    for (int i = 0; i < N; i++) a[i] = makeEmpty();
    return a;
  endfunction

  task automatic idleInputs();
    alloc_valid = 0; alloc_category = 0; alloc_tag = 0;
    upd_pointer = 0; upd_entry = '0;
    commit_valid = 0; commit_tag = 0; st_req_ack = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    idleInputs();
    reset = 1;
    @(posedge clk);
    #2;
    reset = 0;
    #1;
  endtask

  task automatic allocOne(input logic cat, input logic [31:0] tag);
    alloc_valid = 1; alloc_category = cat; alloc_tag = tag;
    tick();
    alloc_valid = 0;
  endtask

  function automatic bit expCommitReady();
    lsq_entry h;
    h = mLsq[mHead];
    return !mWait && !flush && commit_valid && h.valid && (h.tag == commit_tag) &&
           (h.category == 1'b0 || h.ready);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < N; i++) mLsq[i] = makeEmpty();
    mHead = 0; mCount = 0; mColor = 0; mWait = 0;
    mStValid = 0; mStAddr = 0; mStData = 0;
  endtask

  task automatic modelEdge();
    lsq_entry h;
    bit cr, doAlloc, retire;
    int tail, u;
    h = mLsq[mHead];
    cr = expCommitReady();
    doAlloc = alloc_valid && (mCount < N);
    tail = (mHead + mCount) % N;
    if (flush) begin
      for (int i = 0; i < N; i++) mLsq[i] = makeEmpty();
      mHead = 0; mCount = 0; mWait = 0; mStValid = 0;
      return;
    end
    retire = (cr && !h.category) || (mWait && st_req_ack);
    if (upd_pointer >= 1 && upd_pointer <= N) begin
      u = int'(upd_pointer) - 1;
      if (mLsq[u].valid) begin
        mLsq[u].address = upd_entry.address;
        mLsq[u].value   = upd_entry.value;
        mLsq[u].ready   = upd_entry.ready;
      end
    end
    if (doAlloc) begin
      mLsq[tail] = makeEmpty();
      mLsq[tail].valid = 1;
      mLsq[tail].category = alloc_category;
      mLsq[tail].tag = alloc_tag;
      mLsq[tail].color = mColor;
      mColor = mColor + 1;
    end
    if (mWait && st_req_ack) begin
      mWait = 0; mStValid = 0;
    end else if (cr && h.category) begin
      mWait = 1; mStValid = 1; mStAddr = h.address; mStData = h.value;
    end
    if (retire) begin
      mLsq[mHead] = makeEmpty();
      mHead = (mHead + 1) % N;
    end
    mCount = mCount + int'(doAlloc) - int'(retire);
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_alloc_ready: got %b expected 1", alloc_ready); end
    checks++; if (commit_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_commit_ready: got %b expected 0", commit_ready); end
    checks++; if ({st_req_valid, st_req_addr, st_req_data} !== 65'd0) begin errors++; $display("[TB] FAIL rst_st_req: got %b/%h/%h expected 0/0/0", st_req_valid, st_req_addr, st_req_data); end
    checks++; if ({lsq_head, lsq_tail, lsq_empty} !== {3'd0, 3'd0, 1'b1}) begin errors++; $display("[TB] FAIL rst_ptrs: got head %0d tail %0d empty %b expected 0 0 1", lsq_head, lsq_tail, lsq_empty); end
    checks++; if (lsq !== emptyArray()) begin errors++; $display("[TB] FAIL rst_entries: entry0 got %h expected all-empty", lsq[0]); end
  endtask

  task automatic test_alloc_basic();
    allocOne(1'b0, 32'd5);
    allocOne(1'b1, 32'd6);
    checks++; if ({lsq[0].valid, lsq[0].category, lsq[0].tag, lsq[0].color, lsq[0].ready} !== {1'b1, 1'b0, 32'd5, 32'd0, 1'b0}) begin errors++; $display("[TB] FAIL alloc_entry0: got v%b c%b tag %0d color %0d r%b expected v1 c0 tag 5 color 0 r0", lsq[0].valid, lsq[0].category, lsq[0].tag, lsq[0].color, lsq[0].ready); end
    checks++; if ({lsq[1].valid, lsq[1].category, lsq[1].tag, lsq[1].color} !== {1'b1, 1'b1, 32'd6, 32'd1}) begin errors++; $display("[TB] FAIL alloc_entry1: got v%b c%b tag %0d color %0d expected v1 c1 tag 6 color 1", lsq[1].valid, lsq[1].category, lsq[1].tag, lsq[1].color); end
    checks++; if ({lsq_tail, lsq_head, lsq_empty} !== {3'd2, 3'd0, 1'b0}) begin errors++; $display("[TB] FAIL alloc_ptrs: got tail %0d head %0d empty %b expected 2 0 0", lsq_tail, lsq_head, lsq_empty); end
  endtask

  task automatic test_update_store_commit();
    upd_pointer = 2; upd_entry = '0;
    upd_entry.address = 32'h100; upd_entry.value = 32'hAB; upd_entry.ready = 1;
    upd_entry.tag = 32'hDEAD; upd_entry.color = 32'h77;
    tick();
    upd_pointer = 0;
    checks++; if ({lsq[1].address, lsq[1].value, lsq[1].ready, lsq[1].tag, lsq[1].color} !== {32'h100, 32'hAB, 1'b1, 32'd6, 32'd1}) begin errors++; $display("[TB] FAIL upd_entry1: got addr %h val %h r%b tag %0d color %0d expected 100 ab 1 6 1", lsq[1].address, lsq[1].value, lsq[1].ready, lsq[1].tag, lsq[1].color); end
    commit_valid = 1; commit_tag = 5; #1;
    checks++; if (commit_ready !== 1'b1) begin errors++; $display("[TB] FAIL commit_load_ready: got %b expected 1", commit_ready); end
    tick();
    checks++; if ({lsq_head, lsq[0].valid} !== {3'd1, 1'b0}) begin errors++; $display("[TB] FAIL commit_load_retire: got head %0d v%b expected 1 0", lsq_head, lsq[0].valid); end
    commit_tag = 6; #1;
    checks++; if (commit_ready !== 1'b1) begin errors++; $display("[TB] FAIL commit_store_ready: got %b expected 1", commit_ready); end
    tick();
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if ({st_req_valid, st_req_addr, st_req_data, commit_ready, lsq_head} !== {1'b1, 32'h100, 32'hAB, 1'b0, 3'd1}) begin errors++; $display("[TB] FAIL store_wait_%0d: got v%b %h/%h cr%b head %0d expected v1 100/ab cr0 head 1", k, st_req_valid, st_req_addr, st_req_data, commit_ready, lsq_head); end
      tick();
    end
    commit_valid = 0; st_req_ack = 1;
    tick();
    st_req_ack = 0;
    checks++; if ({st_req_valid, lsq_empty, lsq_head, lsq_tail} !== {1'b0, 1'b1, 3'd2, 3'd2}) begin errors++; $display("[TB] FAIL store_ack: got v%b empty %b head %0d tail %0d expected 0 1 2 2", st_req_valid, lsq_empty, lsq_head, lsq_tail); end
  endtask

  task automatic test_full_wrap();
    doReset();
    for (int i = 0; i < N; i++) allocOne(1'(i % 2), 32'(100 + i));
    checks++; if ({alloc_ready, lsq_head, lsq_tail, lsq_empty} !== {1'b0, 3'd0, 3'd0, 1'b0}) begin errors++; $display("[TB] FAIL full_state: got ar%b head %0d tail %0d empty %b expected 0 0 0 0", alloc_ready, lsq_head, lsq_tail, lsq_empty); end
    allocOne(1'b0, 32'd999);
    checks++; if ({lsq[0].tag, lsq_tail} !== {32'd100, 3'd0}) begin errors++; $display("[TB] FAIL full_ninth_alloc: got tag %0d tail %0d expected 100 0", lsq[0].tag, lsq_tail); end
    alloc_valid = 1; alloc_tag = 200; commit_valid = 1; commit_tag = 100; #1;
    checks++; if ({commit_ready, alloc_ready} !== 2'b10) begin errors++; $display("[TB] FAIL full_retire_comb: got cr%b ar%b expected 1 0", commit_ready, alloc_ready); end
    tick();
    commit_valid = 0;
    checks++; if ({lsq_head, lsq_tail, lsq[0].valid} !== {3'd1, 3'd0, 1'b0}) begin errors++; $display("[TB] FAIL full_retire: got head %0d tail %0d v%b expected 1 0 0", lsq_head, lsq_tail, lsq[0].valid); end
    tick();
    alloc_valid = 0;
    checks++; if ({lsq_tail, lsq[0].tag, lsq[0].color} !== {3'd1, 32'd200, 32'd8}) begin errors++; $display("[TB] FAIL wrap_alloc: got tail %0d tag %0d color %0d expected 1 200 8", lsq_tail, lsq[0].tag, lsq[0].color); end
  endtask

  task automatic test_store_not_ready();
    doReset();
    allocOne(1'b1, 32'd7);
    commit_valid = 1; commit_tag = 7; #1;
    checks++; if (commit_ready !== 1'b0) begin errors++; $display("[TB] FAIL notready_commit: got %b expected 0", commit_ready); end
    upd_pointer = 1; upd_entry = '0;
    upd_entry.address = 32'h44; upd_entry.value = 32'h55; upd_entry.ready = 1;
    tick();
    upd_pointer = 0;
    checks++; if ({lsq_head, st_req_valid, lsq[0].valid} !== {3'd0, 1'b0, 1'b1}) begin errors++; $display("[TB] FAIL notready_hold: got head %0d stv %b v%b expected 0 0 1", lsq_head, st_req_valid, lsq[0].valid); end
    #1;
    checks++; if (commit_ready !== 1'b1) begin errors++; $display("[TB] FAIL nowready_commit: got %b expected 1", commit_ready); end
    tick();
    commit_valid = 0;
    checks++; if ({st_req_valid, st_req_addr, st_req_data} !== {1'b1, 32'h44, 32'h55}) begin errors++; $display("[TB] FAIL nowready_req: got v%b %h/%h expected 1 44/55", st_req_valid, st_req_addr, st_req_data); end
    st_req_ack = 1;
    tick();
    st_req_ack = 0;
    checks++; if ({lsq_empty, lsq_head} !== {1'b1, 3'd1}) begin errors++; $display("[TB] FAIL nowready_done: got empty %b head %0d expected 1 1", lsq_empty, lsq_head); end
  endtask

  task automatic test_flush();
    doReset();
    for (int i = 0; i < 5; i++) allocOne(1'(i % 2), 32'(40 + i));
    flush = 1; alloc_valid = 1; alloc_tag = 50;
    tick();
    flush = 0; alloc_valid = 0;
    checks++; if (lsq !== emptyArray()) begin errors++; $display("[TB] FAIL flush_entries: entry0 got %h expected all-empty", lsq[0]); end
    checks++; if ({lsq_head, lsq_tail, lsq_empty, alloc_ready} !== {3'd0, 3'd0, 1'b1, 1'b1}) begin errors++; $display("[TB] FAIL flush_ptrs: got head %0d tail %0d empty %b ar%b expected 0 0 1 1", lsq_head, lsq_tail, lsq_empty, alloc_ready); end
    allocOne(1'b0, 32'd51);
    checks++; if ({lsq[0].tag, lsq[0].color, lsq_tail} !== {32'd51, 32'd5, 3'd1}) begin errors++; $display("[TB] FAIL flush_color: got tag %0d color %0d tail %0d expected 51 5 1", lsq[0].tag, lsq[0].color, lsq_tail); end
  endtask

  task automatic test_reset_mid_store();
    doReset();
    allocOne(1'b1, 32'd9);
    upd_pointer = 1; upd_entry = '0;
    upd_entry.address = 32'h200; upd_entry.value = 32'h300; upd_entry.ready = 1;
    tick();
    upd_pointer = 0; commit_valid = 1; commit_tag = 9;
    tick();
    commit_valid = 0;
    checks++; if (st_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre: got %b expected 1", st_req_valid); end
    #2;
    reset = 1;
    #1;
    checks++; if ({st_req_valid, st_req_addr, st_req_data, lsq_empty, alloc_ready, lsq_head, lsq_tail} !== {1'b0, 64'd0, 1'b1, 1'b1, 3'd0, 3'd0}) begin errors++; $display("[TB] FAIL midrst_outputs: got v%b %h/%h empty %b ar%b head %0d tail %0d expected 0 0/0 1 1 0 0", st_req_valid, st_req_addr, st_req_data, lsq_empty, alloc_ready, lsq_head, lsq_tail); end
    checks++; if (lsq !== emptyArray()) begin errors++; $display("[TB] FAIL midrst_entries: entry0 got %h expected all-empty", lsq[0]); end
    #1;
    reset = 0;
    tick();
  endtask

  task automatic test_random();
    int nextTag;
    lsq_entry [N-1:0] expArr;
    bit expCr;
    nextTag = 1000;
    doReset();
    modelReset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      alloc_valid    = ($urandom_range(0, 99) < 55);
      alloc_category = 1'($urandom_range(0, 1));
      alloc_tag      = 32'(nextTag);
      nextTag++;
      upd_pointer    = (PW+1)'($urandom_range(0, N));
      upd_entry.valid    = 1'($urandom_range(0, 1));
      upd_entry.category = 1'($urandom_range(0, 1));
      upd_entry.tag      = $urandom;
      upd_entry.address  = $urandom;
      upd_entry.value    = $urandom;
      upd_entry.ready    = ($urandom_range(0, 99) < 70);
      upd_entry.color    = $urandom;
      commit_valid   = ($urandom_range(0, 99) < 60);
      commit_tag     = ($urandom_range(0, 9) < 8) ? mLsq[mHead].tag : $urandom;
      st_req_ack     = ($urandom_range(0, 99) < 40);
      flush          = !mWait && ($urandom_range(0, 99) < 3);
      #1;
      expCr = expCommitReady();
      checks++; if (alloc_ready !== (mCount < N)) begin errors++; $display("[TB] FAIL rnd_alloc_ready cyc %0d: got %b expected %b", cyc, alloc_ready, (mCount < N)); end
      checks++; if (commit_ready !== expCr) begin errors++; $display("[TB] FAIL rnd_commit_ready cyc %0d: got %b expected %b", cyc, commit_ready, expCr); end
      modelEdge();
      tick();
      for (int i = 0; i < N; i++) expArr[i] = mLsq[i];
      checks++; if ({lsq_head, lsq_tail, lsq_empty} !== {PW'(mHead), PW'((mHead + mCount) % N), (mCount == 0)}) begin errors++; $display("[TB] FAIL rnd_ptrs cyc %0d: got head %0d tail %0d empty %b expected %0d %0d %b", cyc, lsq_head, lsq_tail, lsq_empty, mHead, (mHead + mCount) % N, (mCount == 0)); end
      checks++; if ({st_req_valid, st_req_addr, st_req_data} !== {mStValid, mStAddr, mStData}) begin errors++; $display("[TB] FAIL rnd_st_req cyc %0d: got v%b %h/%h expected v%b %h/%h", cyc, st_req_valid, st_req_addr, st_req_data, mStValid, mStAddr, mStData); end
      checks++;
      if (lsq !== expArr) begin
        errors++;
        for (int i = 0; i < N; i++)
          if (lsq[i] !== expArr[i]) $display("[TB] FAIL rnd_entry cyc %0d slot %0d: got %h expected %h", cyc, i, lsq[i], expArr[i]);
      end
    end
    idleInputs();
  endtask

  initial begin
    reset = 0;
    idleInputs();
    #2;
    test_reset();
    test_alloc_basic();
    test_update_store_commit();
    test_full_wrap();
    test_store_not_ready();
    test_flush();
    test_reset_mid_store();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
